tb_obi_arbiter: RTL and testbench

TB_OBI_ARBITER -- requirements
Module: tb_obi_arbiter

---
 rtl/tb_obi_arbiter.sv | 152 +++++++++++++++
 tb/tb_tb_obi_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tb_obi_arbiter.sv
// Two-master OBI arbiter in front of a single-port memory.
// Round-robin selection between an instruction master (m0) and a data
// master (m1); the selection is held while the memory stalls a request.
// A small ID FIFO routes the in-order memory responses back to their
// originators with no added latency.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   m{0,1}_req/addr/we/be/wdata_i    master request channels
//   m{0,1}_gnt_o, m{0,1}_rvalid_o    grant / response valid per master
//   m{0,1}_rdata_o                   response data (from mem_rdata_i)
//   mem_req/addr/we/be/wdata_o       request to the memory
//   mem_gnt_i, mem_rvalid_i          memory grant / response valid
//   mem_rdata_i                      memory response data
//   protocol_err_o                   sticky: response with nothing outstanding
module tb_obi_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  protocol_err_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic            locked_sel;
    logic            rr;              // ID granted most recently
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            id_fifo [DEPTH];

    state_t          state_e;
    logic            rr_e;
    logic [CW-1:0]   count_e;
    logic [PW-1:0]   rd_ptr_e;
    logic            sel;
    logic            grant;
    logic            pop;
    logic            head;
    logic            locked_req;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Selection, grant and response routing; while rst_i is high the
    // outputs are derived from the reset state rather than stale registers.
    always_comb begin
        state_e  = rst_i ? IDLE : state;
        rr_e     = rst_i ? 1'b1 : rr;
        count_e  = rst_i ? '0 : count;
        rd_ptr_e = rst_i ? '0 : rd_ptr;

        mem_req_o = (m0_req_i | m1_req_i) & (count_e < CW'(DEPTH));

        if (state_e == LOCKED)
            sel = locked_sel;
        else if (m0_req_i & m1_req_i)
            sel = ~rr_e;
        else
            sel = m1_req_i;

        locked_req = locked_sel ? m1_req_i : m0_req_i;

        grant    = mem_req_o & mem_gnt_i;
        m0_gnt_o = grant & ~sel;
        m1_gnt_o = grant & sel;

        pop         = mem_rvalid_i & (count_e != '0);
        head        = id_fifo[rd_ptr_e];
        m0_rvalid_o = pop & ~head;
        m1_rvalid_o = pop & head;
        m0_rdata_o  = mem_rdata_i;
        m1_rdata_o  = mem_rdata_i;

        mem_addr_o  = sel ? m1_addr_i  : m0_addr_i;
        mem_we_o    = sel ? m1_we_i    : m0_we_i;
        mem_be_o    = sel ? m1_be_i    : m0_be_i;
        mem_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
    end

    // Arbiter state, round-robin pointer, outstanding-ID FIFO, error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            locked_sel     <= 1'b0;
            rr             <= 1'b1;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_o & ~mem_gnt_i) begin
                        state      <= LOCKED;
                        locked_sel <= sel;
                    end
                end
                LOCKED: begin
                    // A dropped request while stalled is tolerated by unlocking.
                    if (mem_gnt_i | ~locked_req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (grant) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
                rr              <= sel;
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            count <= count + CW'(grant) - CW'(pop);

            if (mem_rvalid_i & (count == '0))
                protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tb_obi_arbiter.sv
// Randomized scoreboard bench for the two-master OBI arbiter.
// The driver predicts grants from a behavioural model (outstanding count,
// last-granted master, stall lock) and queues the granted IDs; a separate
// monitor pops that queue whenever the memory answers and checks routing.
module tb_tb_obi_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m0_req_i, m1_req_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_we_i, m1_we_i;
    logic [3:0]    m0_be_i, m1_be_i;
    logic [31:0]   m0_wdata_i, m1_wdata_i;
    logic          m0_gnt_o, m1_gnt_o;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic [31:0]   m0_rdata_o, m1_rdata_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic          protocol_err_o;

    always #5 clk = ~clk;

    tb_obi_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .protocol_err_o(protocol_err_o)
    );

    // Reference model state
    int  n_out;      // transactions granted and not yet answered
    bit  last;       // master granted most recently
    bit  locked;     // a stalled request is holding the selection
    bit  lock_id;
    bit  err_m;
    int  exp_q[$];   // scoreboard: granted IDs in order

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check predicted outputs, advance model.
    task automatic step(input bit rst, input bit r0, input bit r1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input bit g, input bit rv, input logic [31:0] rd,
                        output bit gnt0, output bit gnt1);
        int  ne;
        bit  laste, lockede, sel, mreq, gnt, pop;
        logic        we0, we1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic [127:0] exp_mux;

        we0 = 1'($urandom); we1 = 1'($urandom);
        be0 = 4'($urandom); be1 = 4'($urandom);
        wd0 = $urandom;     wd1 = $urandom;

        rst_i = rst;
        m0_req_i = r0; m0_addr_i = a0; m0_we_i = we0; m0_be_i = be0; m0_wdata_i = wd0;
        m1_req_i = r1; m1_addr_i = a1; m1_we_i = we1; m1_be_i = be1; m1_wdata_i = wd1;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;

        ne      = rst ? 0 : n_out;
        laste   = rst ? 1'b1 : last;
        lockede = rst ? 1'b0 : locked;
        if (lockede)      sel = lock_id;
        else if (r0 && r1) sel = !laste;
        else              sel = r1;
        mreq = (r0 || r1) && (ne < DEPTH);
        gnt  = mreq && g;
        gnt0 = gnt && !sel;
        gnt1 = gnt && sel;
        exp_mux = sel ? {59'd0, a1, we1, be1, wd1} : {59'd0, a0, we0, be0, wd0};

        @(negedge clk);
        check("mem_req", 128'(mem_req_o), 128'(mreq));
        check("m0_gnt", 128'(m0_gnt_o), 128'(gnt0));
        check("m1_gnt", 128'(m1_gnt_o), 128'(gnt1));
        check("protocol_err", 128'(protocol_err_o), 128'(err_m));
        if (mreq)
            check("mem_mux", {59'd0, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}, exp_mux);

        @(posedge clk);
        if (rst) begin
            n_out = 0; last = 1'b1; locked = 1'b0; err_m = 1'b0;
            exp_q.delete();
        end else begin
            pop = rv && (n_out > 0);
            if (rv && n_out == 0) err_m = 1'b1;
            if (gnt) begin
                exp_q.push_back(int'(sel));
                last   = sel;
                locked = 1'b0;
            end else if (locked && !(lock_id ? r1 : r0)) begin
                locked = 1'b0;
            end else if (!locked && mreq) begin
                locked  = 1'b1;
                lock_id = sel;
            end
            n_out = n_out + int'(gnt) - int'(pop);
        end
        #1;
    endtask

    // Response monitor: routes each memory response against the queued IDs.
    always @(negedge clk) begin
        int id;
        if (rst_i) begin
            check("rvalid_in_reset", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(2'b00));
        end else if (mem_rvalid_i && exp_q.size() > 0) begin
            id = exp_q.pop_front();
            check("rvalid_route", 128'({m1_rvalid_o, m0_rvalid_o}),
                  128'((id == 1) ? 2'b10 : 2'b01));
            check("rdata", 128'({m1_rdata_o, m0_rdata_o}), 128'({mem_rdata_i, mem_rdata_i}));
        end else begin
            check("rvalid_idle", 128'({m1_rvalid_o, m0_rvalid_o}), 128'(2'b00));
        end
    end

    initial begin
        bit g0, g1;
        bit pend0, pend1;
        logic [AW-1:0] ad0, ad1;
        bit rst, g, rv;

        n_out = 0; last = 1'b1; locked = 1'b0; lock_id = 1'b0; err_m = 1'b0;
        rst_i = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0;
        m0_addr_i = '0; m1_addr_i = '0; m0_we_i = 1'b0; m1_we_i = 1'b0;
        m0_be_i = '0; m1_be_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Single m0 read, response one cycle later
        step(0, 1, 0, 32'h180, 0, 1, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, g0, g1);

        // Both masters back-to-back, responses one cycle behind
        step(0, 1, 1, 32'h100, 32'h200, 1, 0, 32'h11, g0, g1);
        for (int i = 0; i < 6; i++)
            step(0, 1, 1, 32'h104 + 4*i, 32'h204 + 4*i, 1, 1, 32'h20 + i, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h77, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Stalled m1 keeps the bus while m0 arrives
        step(0, 0, 1, 0, 32'h300, 0, 0, 0, g0, g1);
        step(0, 1, 1, 32'h400, 32'h300, 0, 0, 0, g0, g1);
        step(0, 1, 1, 32'h400, 32'h300, 0, 0, 0, g0, g1);
        step(0, 1, 1, 32'h400, 32'h300, 1, 0, 0, g0, g1);
        step(0, 1, 0, 32'h400, 0, 1, 1, 32'h55, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h66, g0, g1);

        // Full outstanding window blocks grants, even with a same-cycle response
        step(0, 1, 0, 32'h500, 0, 1, 0, 0, g0, g1);
        step(0, 1, 0, 32'h504, 0, 1, 0, 0, g0, g1);
        step(0, 1, 1, 32'h508, 32'h600, 1, 0, 0, g0, g1);
        step(0, 1, 1, 32'h508, 32'h600, 1, 1, 32'h1, g0, g1);
        step(0, 1, 1, 32'h508, 32'h600, 1, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h2, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h3, g0, g1);

        // Spurious response sets the sticky error; reset clears it
        step(0, 0, 0, 0, 0, 0, 1, 32'h9, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Reset with a transaction outstanding; the late response is an error
        step(0, 0, 1, 0, 32'h700, 1, 0, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, 1, 32'hA, g0, g1);
        step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
        step(1, 0, 0, 0, 0, 0, 0, 0, g0, g1);

        // Randomized traffic; masters hold requests until granted
        pend0 = 0; pend1 = 0; ad0 = '0; ad1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend0 && $urandom_range(0, 9) < 6) begin
                pend0 = 1; ad0 = {$urandom} & ~32'h3;
            end
            if (!pend1 && $urandom_range(0, 9) < 6) begin
                pend1 = 1; ad1 = {$urandom} & ~32'h3;
            end
            rst = ($urandom_range(0, 99) == 0);
            g   = ($urandom_range(0, 2) != 0);
            rv  = (n_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            step(rst, pend0, pend1, ad0, ad1, g, rv, $urandom, g0, g1);
            if (g0) pend0 = 0;
            if (g1) pend1 = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
